// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer that borrows the shared EX-stage ALU, one add/sub per cycle.
// Optional mthi/mtlo write port enabled by defining MULDIV_HILO_WRITE_EN.
//   state | meaning
//   IDLE  | waiting for start; HI/LO stable
//   PREP  | operand magnitudes and sign flags
//   ITER  | 32 shift-add / restoring-subtract steps on the shared ALU
//   FIX   | sign correction, HI/LO written
//   DONE  | done pulse
module muldiv_seq #(
  parameter int          WIDTH   = 32,
  parameter logic [3:0]  ALU_ADD = 4'b0010,
  parameter logic [3:0]  ALU_SUB = 4'b0110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic [WIDTH-1:0] alu_res,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata
);

  localparam int CW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] acc;     // product high half / partial remainder
  logic [WIDTH-1:0] mq;      // multiplier / quotient
  logic [WIDTH-1:0] mcand;   // multiplicand / divisor
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             is_signed;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_neg;
  logic               carry;
  logic               borrow;

  assign r_shift  = {acc[MSB-1:0], mq[MSB]};
  assign a_mag    = (is_signed && mq[MSB])    ? -mq    : mq;
  assign b_mag    = (is_signed && mcand[MSB]) ? -mcand : mcand;
  assign prod_neg = -{acc, mq};

  always_comb begin
    alu_req = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = ALU_ADD;
    if (state == S_ITER) begin
      alu_req = 1'b1;
      if (is_div) begin
        alu_a   = r_shift;
        alu_b   = mcand;
        alu_ctr = ALU_SUB;
      end else begin
        alu_a   = acc;
        alu_b   = mq[0] ? mcand : '0;
      end
    end
  end

  assign carry  = (alu_a[MSB] & alu_b[MSB]) | ((alu_a[MSB] | alu_b[MSB]) & ~alu_res[MSB]);
  assign borrow = (~alu_a[MSB] & alu_b[MSB]) | (~(alu_a[MSB] ^ alu_b[MSB]) & alu_res[MSB]);

  assign busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
  assign done = (state == S_DONE);

`ifndef MULDIV_HILO_WRITE_EN
  logic unused_hilo;
  assign unused_hilo = ^{hilo_we, hilo_wdata};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      mq        <= '0;
      mcand     <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (flush && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
`ifdef MULDIV_HILO_WRITE_EN
          if (hilo_we[1]) hi <= hilo_wdata;
          if (hilo_we[0]) lo <= hilo_wdata;
`endif
          if (start && !flush) begin
            is_div    <= op[1];
            is_signed <= ~op[0];
            mq        <= src_a;
            mcand     <= src_b;
            state     <= S_PREP;
          end
        end
        S_PREP: begin
          mq    <= a_mag;
          mcand <= b_mag;
          neg_q <= is_signed & (mq[MSB] ^ mcand[MSB]);
          neg_r <= is_signed & mq[MSB];
          acc   <= '0;
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            if (acc[MSB] || !borrow) begin
              acc <= alu_res;
              mq  <= {mq[MSB-1:0], 1'b1};
            end else begin
              acc <= r_shift;
              mq  <= {mq[MSB-1:0], 1'b0};
            end
          end else begin
            acc <= {carry, alu_res[MSB:1]};
            mq  <= {alu_res[0], mq[MSB:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= neg_r ? -acc : acc;
            lo <= neg_q ? -mq  : mq;
          end else if (neg_q) begin
            {hi, lo} <= prod_neg;
          end else begin
            {hi, lo} <= {acc, mq};
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-position reference model plus directed and random stimulus.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op, hilo_we;
  logic [31:0] src_a, src_b, alu_res, alu_a, alu_b, hi, lo, hilo_wdata;
  logic [3:0]  alu_ctr;
  logic        alu_req, busy, done;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .alu_res(alu_res), .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctr(alu_ctr), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata)
  );

  // shared ALU stand-in
  assign alu_res = (alu_ctr == 4'b0010) ? alu_a + alu_b :
                   (alu_ctr == 4'b0110) ? alu_a - alu_b : 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi, lo} an operation must produce, from plain arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] ma, mb, q, r;
    bit          sgn;
    case (o)
      2'b00: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      default: begin
        sgn = (o == 2'b10);
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (mb == 0) begin
          q = 32'hFFFF_FFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {r, q};
      end
    endcase
  endfunction

  // m_pos: 0 idle, 1 prep, 2..33 ALU steps, 34 fixup, 35 done pulse
  int          m_pos = 0;
  bit          m_div = 1'b0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_res = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_hi = 0; m_lo = 0;
    end else if (m_pos != 0 && flush) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
`ifdef MULDIV_HILO_WRITE_EN
      if (hilo_we[1]) m_hi = hilo_wdata;
      if (hilo_we[0]) m_lo = hilo_wdata;
`endif
      if (start && !flush) begin
        m_pos = 1;
        m_div = op[1];
        m_res = ref_result(op, src_a, src_b);
      end
    end else if (m_pos == 35) begin
      m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos == 35) {m_hi, m_lo} = m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_pos >= 1 && m_pos <= 34));
      check("done", 64'(done), 64'(m_pos == 35));
      check("alu_req", 64'(alu_req), 64'(m_pos >= 2 && m_pos <= 33));
      if (m_pos >= 2 && m_pos <= 33) begin
        check("alu_ctr_iter", 64'(alu_ctr), m_div ? 64'h6 : 64'h2);
      end else begin
        check("alu_a_idle", 64'(alu_a), 64'h0);
        check("alu_b_idle", 64'(alu_b), 64'h0);
        check("alu_ctr_idle", 64'(alu_ctr), 64'h2);
      end
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int req_cycles);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    req_cycles = int'(alu_req);
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      req_cycles += int'(alu_req);
    end
    @(negedge clk);
  endtask

  logic [1:0]  d_op [7] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3};
  logic [31:0] d_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h11};
  logic [31:0] d_b  [7] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'h22};
  logic [31:0] d_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd100, 32'h0, 32'h11};
  logic [31:0] d_lo [7] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000, 32'h0};

  logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(3))
      0:       return $urandom_range(15);
      1:       return specials[$urandom_range(4)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, req, n_done;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0;
    src_a = 0; src_b = 0; hilo_we = 2'b00; hilo_wdata = 0;

    check("ref_mult", ref_result(2'd0, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    check("ref_divu", ref_result(2'd3, 32'd100, 32'd7), {32'd2, 32'd14});
    check("ref_div0", ref_result(2'd2, 32'hFFFFFFF9, 32'd0), {32'hFFFFFFF9, 32'h1});

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], lat, req);
      check("latency", 64'(lat), 64'd35);
      check("alu_req_cycles", 64'(req), 64'd32);
      check("dir_hi", 64'(hi), 64'(d_hi[i]));
      check("dir_lo", 64'(lo), 64'(d_lo[i]));
    end

    // flush at start+10
    op = 2'd0; src_a = 3; src_b = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'h0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      n_done += int'(done);
    end
    check("flush_no_done", 64'(n_done), 64'h0);
    check("flush_hi", 64'(hi), 64'h11);
    check("flush_lo", 64'(lo), 64'h0);

    // second start while busy is ignored
    op = 2'd1; src_a = 5; src_b = 6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'd0; src_a = 7; src_b = 7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    repeat (45) begin
      @(negedge clk);
      n_done += int'(done);
    end
    check("single_done", 64'(n_done), 64'd1);
    check("restart_lo", 64'(lo), 64'd30);
    check("restart_hi", 64'(hi), 64'd0);

    // reset at start+20
    op = 2'd0; src_a = 3; src_b = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_req", 64'(alu_req), 64'h0);
    check("rst_mid_ctr", 64'(alu_ctr), 64'h2);
    check("rst_mid_hi", 64'(hi), 64'h0);
    check("rst_mid_lo", 64'(lo), 64'h0);

    // random traffic; the compare process checks every cycle
    n_done = 0;
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(599) == 0);
      flush      = ($urandom_range(99) == 0);
      start      = ($urandom_range(3) == 0);
      op         = 2'($urandom_range(3));
      src_a      = pick_operand();
      src_b      = pick_operand();
      hilo_we    = 2'($urandom_range(3));
      hilo_wdata = $urandom;
      @(negedge clk);
      n_done += int'(done);
    end
    rst = 1'b0; flush = 1'b0; start = 1'b0; hilo_we = 2'b00;
    check("random_ops_completed", 64'(n_done > 20), 64'h1);
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
